multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter STATE_W, default 4, giving the state register width.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates happen on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-004 SHALL have ports op[6:0] (opcode), funct3[2:0], funct7b5 and zero, all inputs, taken from the external instruction register and ALU.
REQ-005 SHALL have 1-bit outputs pcwrite, adrsrc, memwrite, irwrite and regwrite.
REQ-006 SHALL have 2-bit outputs resultsrc, alusrca, alusrcb and immsrc, plus a 3-bit output alucontrol.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ and JAL.
REQ-008 SHALL advance FETCH->DECODE unconditionally.
REQ-009 SHALL branch from DECODE on op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other op -> FETCH (illegal opcode; no write enable asserted)
REQ-010 SHALL go MEMADR->MEMREAD when op=0000011 and MEMADR->MEMWRITE otherwise; MEMREAD->MEMWB.
REQ-011 SHALL go EXECUTER, EXECUTEI and JAL -> ALUWB; MEMWB, MEMWRITE, ALUWB and BEQ -> FETCH.
REQ-012 SHALL drive these outputs per state (unlisted outputs are 0):
- FETCH: irwrite=1, pcupdate=1, alusrcb=10, resultsrc=10
- DECODE: alusrca=01, alusrcb=01
- MEMADR: alusrca=10, alusrcb=01
- MEMREAD: adrsrc=1
- MEMWRITE: adrsrc=1, memwrite=1
- MEMWB: resultsrc=01, regwrite=1
- EXECUTER: alusrca=10, aluop=10
- EXECUTEI: alusrca=10, alusrcb=01, aluop=10
- ALUWB: regwrite=1
- BEQ: alusrca=10, aluop=01, branch=1
- JAL: alusrca=01, alusrcb=10, pcupdate=1
REQ-013 SHALL compute pcwrite = pcupdate OR (branch AND zero), combinationally within the same cycle.
REQ-014 SHALL decode immsrc combinationally from op, independent of state:
- 0100011 -> 01 (S)
- 1100011 -> 10 (B)
- 1101111 -> 11 (J)
- otherwise -> 00 (I)
REQ-015 SHALL decode alucontrol from aluop, funct3, op[5] and funct7b5:
- aluop 00 -> 000 (add); aluop 01 -> 001 (sub)
- aluop 10, funct3 000 -> 001 when op[5] and funct7b5 are both 1, else 000
- aluop 10, funct3 010 -> 101; 110 -> 011; 111 -> 010
- any other funct3 -> 000
REQ-016 SHALL give these cycle counts from FETCH back to FETCH:
- lw: 5
- sw, R-type, I-ALU, jal: 4
- beq: 3
- illegal opcode: 2
REQ-017 SHALL treat an unreachable state encoding as FETCH on the next edge, with all outputs at their inactive values.

Reset
REQ-018 SHALL force the state to FETCH immediately on rst_n low, without waiting for clk.
REQ-019 SHALL, while rst_n is low, hold pcwrite, irwrite, memwrite and regwrite at 0 and every other output at 0, except immsrc and alucontrol, which remain combinational.
REQ-020 SHALL, on reset mid-instruction, abandon that instruction with no further write enables; the first edge after release evaluates FETCH.

Structure
REQ-021 SHALL place the state enumeration, the opcode constants and the immsrc/aluop/alucontrol encodings in a shared package, also used by immediategeneration's users.
REQ-022 SHALL instantiate one sub-module, alu_decoder, covering REQ-015.

Verification
REQ-023 SHALL cover: lw, op=0000011 -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in cycle 5; immsrc=00 throughout.
REQ-024 SHALL cover: sw, op=0100011 -> memwrite=1 only in cycle 4; immsrc=01; regwrite never 1.
REQ-025 SHALL cover: beq, op=1100011 -> with zero=1, pcwrite=1 in cycle 3 with alucontrol=001; with zero=0, pcwrite=0 in cycle 3.
REQ-026 SHALL cover: R-type sub, op=0110011, funct3=000, funct7b5=1 -> alucontrol=001 in EXECUTER and regwrite=1 in ALUWB; the same with op=0010011 -> alucontrol=000.
REQ-027 SHALL cover: jal, op=1101111 -> immsrc=11 and pcwrite=1 in JAL, regwrite=1 in ALUWB; an illegal op=1111111 -> return to FETCH after DECODE with no write enable.
REQ-028 SHALL cover: rst_n dropped asynchronously in MEMREAD -> state=FETCH and all write enables 0 before the next clk edge; after release, a normal fetch occurs.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RISC-V controller: FSM states, opcodes,
// immediate-format select, ALU operation class and ALU control codes.
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alucontrol_e;

  // Immediate format depends only on the opcode, never on the FSM state.
  function automatic logic [1:0] imm_decode(input logic [6:0] op);
    case (op)
      OP_STORE:  imm_decode = IMM_S;
      OP_BRANCH: imm_decode = IMM_B;
      OP_JAL:    imm_decode = IMM_J;
      default:   imm_decode = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU control decode: maps the FSM's ALU operation class plus instruction
// funct fields onto the ALU's 3-bit operation select.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [2:0] funct3_i,
  input  logic       opb5_i,
  input  logic       funct7b5_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_ADD: alucontrol_o = ALU_ADD;
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only register-register sub has op[5]=1; addi with imm[10]=1 stays add.
          3'b000:  alucontrol_o = (opb5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol_o = ALU_SLT;
          3'b110:  alucontrol_o = ALU_OR;
          3'b111:  alucontrol_o = ALU_AND;
          default: alucontrol_o = ALU_ADD;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-FSM control unit for a multicycle RISC-V datapath (lw/sw/R/I/beq/jal).
// Write enables are forced low while rst_n is asserted.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int unsigned STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] immsrc,
  output logic [2:0] alucontrol
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               pcupdate;
  logic               branch;
  logic [1:0]         aluop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STATE_W'(S_FETCH);
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = STATE_W'(S_FETCH);
    case (state_q)
      STATE_W'(S_FETCH): state_d = STATE_W'(S_DECODE);
      STATE_W'(S_DECODE): begin
        case (op)
          OP_LOAD, OP_STORE: state_d = STATE_W'(S_MEMADR);
          OP_RTYPE:          state_d = STATE_W'(S_EXECUTER);
          OP_ITYPE:          state_d = STATE_W'(S_EXECUTEI);
          OP_BRANCH:         state_d = STATE_W'(S_BEQ);
          OP_JAL:            state_d = STATE_W'(S_JAL);
          default:           state_d = STATE_W'(S_FETCH);
        endcase
      end
      STATE_W'(S_MEMADR):
        state_d = (op == OP_LOAD) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
      STATE_W'(S_MEMREAD):  state_d = STATE_W'(S_MEMWB);
      STATE_W'(S_EXECUTER),
      STATE_W'(S_EXECUTEI),
      STATE_W'(S_JAL):      state_d = STATE_W'(S_ALUWB);
      default:              state_d = STATE_W'(S_FETCH);
    endcase
  end

  always_comb begin
    pcupdate  = 1'b0;
    branch    = 1'b0;
    aluop     = ALUOP_ADD;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = '0;
    alusrca   = '0;
    alusrcb   = '0;
    case (state_q)
      STATE_W'(S_FETCH): begin
        irwrite   = 1'b1;
        pcupdate  = 1'b1;
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
      end
      STATE_W'(S_DECODE): begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
      end
      STATE_W'(S_MEMADR): begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
      end
      STATE_W'(S_MEMREAD): adrsrc = 1'b1;
      STATE_W'(S_MEMWRITE): begin
        adrsrc   = 1'b1;
        memwrite = 1'b1;
      end
      STATE_W'(S_MEMWB): begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
      end
      STATE_W'(S_EXECUTER): begin
        alusrca = 2'b10;
        aluop   = ALUOP_FUNCT;
      end
      STATE_W'(S_EXECUTEI): begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): regwrite = 1'b1;
      STATE_W'(S_BEQ): begin
        alusrca = 2'b10;
        aluop   = ALUOP_SUB;
        branch  = 1'b1;
      end
      STATE_W'(S_JAL): begin
        alusrca  = 2'b01;
        alusrcb  = 2'b10;
        pcupdate = 1'b1;
      end
      default: ;
    endcase
    // State already reads FETCH during reset; this keeps FETCH's enables quiet too.
    if (!rst_n) begin
      pcupdate  = 1'b0;
      branch    = 1'b0;
      aluop     = ALUOP_ADD;
      adrsrc    = 1'b0;
      memwrite  = 1'b0;
      irwrite   = 1'b0;
      regwrite  = 1'b0;
      resultsrc = '0;
      alusrca   = '0;
      alusrcb   = '0;
    end
  end

  assign pcwrite = pcupdate | (branch & zero);
  assign immsrc  = imm_decode(op);

  alu_decoder u_alu_decoder (
    .aluop_i      (aluop),
    .funct3_i     (funct3),
    .opb5_i       (op[5]),
    .funct7b5_i   (funct7b5),
    .alucontrol_o (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table over every
// instruction class, plus reset sequences (idle and mid-instruction).
module tb_multicycle_controller;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] immsrc;
    logic [2:0] alucontrol;
  } out_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    out_t       exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite;
  logic [1:0] resultsrc, alusrca, alusrcb, immsrc;
  logic [2:0] alucontrol;
  out_t       act;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  vec_t        vecs[$];

  always #5 clk = ~clk;

  multicycle_controller #(.STATE_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .pcwrite    (pcwrite),
    .adrsrc     (adrsrc),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regwrite   (regwrite),
    .resultsrc  (resultsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .immsrc     (immsrc),
    .alucontrol (alucontrol)
  );

  assign act = '{pcwrite, adrsrc, memwrite, irwrite, regwrite,
                 resultsrc, alusrca, alusrcb, immsrc, alucontrol};

  function automatic string fmt(input out_t o);
    return $sformatf("pcw=%b adr=%b mw=%b irw=%b rw=%b rs=%b asa=%b asb=%b imm=%b alu=%b",
                     o.pcwrite, o.adrsrc, o.memwrite, o.irwrite, o.regwrite,
                     o.resultsrc, o.alusrca, o.alusrcb, o.immsrc, o.alucontrol);
  endfunction

  task automatic check(input string name, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} want {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic row(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z,
                     input logic pcw, input logic adr, input logic mw, input logic irw,
                     input logic rw, input logic [1:0] rs, input logic [1:0] asa,
                     input logic [1:0] asb, input logic [1:0] imm, input logic [2:0] alu);
    vec_t v;
    v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z;
    v.exp = '{pcw, adr, mw, irw, rw, rs, asa, asb, imm, alu};
    vecs.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, want end before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    //   name          op          f3     f7  z   pcw adr mw irw rw  rs     asa    asb    imm    alu
    row("lw.fetch",    7'b0000011, 3'b010, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("lw.decode",   7'b0000011, 3'b010, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("lw.memadr",   7'b0000011, 3'b010, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    row("lw.memread",  7'b0000011, 3'b010, 0, 0,  0,  1,  0, 0,  0,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("lw.memwb",    7'b0000011, 3'b010, 0, 0,  0,  0,  0, 0,  1,  2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    row("ill.fetch",   7'b1111111, 3'b000, 0, 1,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("ill.decode",  7'b1111111, 3'b000, 0, 1,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("sw.fetch",    7'b0100011, 3'b010, 0, 1,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    row("sw.decode",   7'b0100011, 3'b010, 0, 1,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
    row("sw.memadr",   7'b0100011, 3'b010, 0, 1,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    row("sw.memwrite", 7'b0100011, 3'b010, 0, 1,  0,  1,  1, 0,  0,  2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    row("beq1.fetch",  7'b1100011, 3'b000, 0, 1,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    row("beq1.decode", 7'b1100011, 3'b000, 0, 1,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    row("beq1.beq",    7'b1100011, 3'b000, 0, 1,  1,  0,  0, 0,  0,  2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    row("beq0.fetch",  7'b1100011, 3'b000, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    row("beq0.decode", 7'b1100011, 3'b000, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    row("beq0.beq",    7'b1100011, 3'b000, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    row("sub.fetch",   7'b0110011, 3'b000, 1, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("sub.decode",  7'b0110011, 3'b000, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("sub.exec",    7'b0110011, 3'b000, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    row("sub.aluwb",   7'b0110011, 3'b000, 1, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("addi.fetch",  7'b0010011, 3'b000, 1, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("addi.decode", 7'b0010011, 3'b000, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("addi.exec",   7'b0010011, 3'b000, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    row("addi.aluwb",  7'b0010011, 3'b000, 1, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("or.fetch",    7'b0110011, 3'b110, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("or.decode",   7'b0110011, 3'b110, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("or.exec",     7'b0110011, 3'b110, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b00, 2'b00, 3'b011);
    row("or.aluwb",    7'b0110011, 3'b110, 0, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("slti.fetch",  7'b0010011, 3'b010, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("slti.decode", 7'b0010011, 3'b010, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("slti.exec",   7'b0010011, 3'b010, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b01, 2'b00, 3'b101);
    row("slti.aluwb",  7'b0010011, 3'b010, 0, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("and.fetch",   7'b0110011, 3'b111, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("and.decode",  7'b0110011, 3'b111, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("and.exec",    7'b0110011, 3'b111, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
    row("and.aluwb",   7'b0110011, 3'b111, 0, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("xori.fetch",  7'b0010011, 3'b100, 1, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    row("xori.decode", 7'b0010011, 3'b100, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    row("xori.exec",   7'b0010011, 3'b100, 1, 0,  0,  0,  0, 0,  0,  2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    row("xori.aluwb",  7'b0010011, 3'b100, 1, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    row("jal.fetch",   7'b1101111, 3'b000, 0, 0,  1,  0,  0, 1,  0,  2'b10, 2'b00, 2'b10, 2'b11, 3'b000);
    row("jal.decode",  7'b1101111, 3'b000, 0, 0,  0,  0,  0, 0,  0,  2'b00, 2'b01, 2'b01, 2'b11, 3'b000);
    row("jal.jal",     7'b1101111, 3'b000, 0, 0,  1,  0,  0, 0,  0,  2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    row("jal.aluwb",   7'b1101111, 3'b000, 0, 0,  0,  0,  0, 0,  1,  2'b00, 2'b00, 2'b00, 2'b11, 3'b000);

    // Reset held: FETCH's enables suppressed, immsrc still follows op.
    op = 7'b1101111; zero = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.idle", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000});
    @(posedge clk); #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; zero = vecs[i].z;
      @(negedge clk);
      check(vecs[i].name, vecs[i].exp);
      @(posedge clk); #1;
    end

    // Mid-instruction reset: lw walked into MEMREAD, then rst_n dropped between edges.
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst.memread", '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000});
    #1 rst_n = 1'b0;
    #1;
    check("rst.async", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000});
    op = 7'b0100011;
    @(negedge clk);
    check("rst.held", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000});
    @(posedge clk); #1;
    check("rst.edge", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000});
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.fetch", '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000});
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.decode", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000});
    @(posedge clk); #1;
    @(negedge clk);
    check("rst.memadr", '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
